// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game: press-FSM state encodings, the
// button count and the button index constants used by both the input
// conditioner and the game FSM.
package simon_pkg;

  localparam int NUM_BTN = 4;

  localparam logic [1:0] BTN_0 = 2'd0;
  localparam logic [1:0] BTN_1 = 2'd1;
  localparam logic [1:0] BTN_2 = 2'd2;
  localparam logic [1:0] BTN_3 = 2'd3;

  typedef enum logic [1:0] {
    S_ARM  = 2'd0,
    S_IDLE = 2'd1,
    S_HELD = 2'd2
  } press_state_e;

  // Number of set bits in a button vector.
  function automatic logic [2:0] count_set(input logic [NUM_BTN-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  // Index of the highest set bit; only meaningful when exactly one bit is set.
  function automatic logic [1:0] btn_index(input logic [NUM_BTN-1:0] v);
    logic [1:0] idx;
    idx = BTN_0;
    if (v[1]) idx = BTN_1;
    if (v[2]) idx = BTN_2;
    if (v[3]) idx = BTN_3;
    return idx;
  endfunction

endpackage

// File: rtl/simon_debounce.sv
// Single-bit button conditioner: two-flop synchronizer followed by a
// consecutive-sample debounce counter.
//   clk_tick  in   block clock
//   reset_n   in   synchronous active-low reset
//   btn_raw   in   raw asynchronous button level
//   btn_db    out  debounced level
//   quiet     out  1 when the synchronizer and counter agree with btn_db
//                  (nothing in flight for this bit)
module simon_debounce #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 4
) (
  input  logic clk_tick,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_db,
  output logic quiet
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = cnt_q;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_tick) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_db = db_q;
  assign quiet  = (sync1_q == db_q) && (sync2_q == db_q) && (cnt_q == '0);

endmodule

// File: rtl/simon_btn_cond.sv
// Simon input conditioner: debounces four raw buttons and turns each
// physical press into one btn_valid pulse carrying the button index, with
// lockout for held buttons and a multi_err pulse for chorded presses.
//   clk_tick   in   block clock (game tick)
//   reset_n    in   synchronous active-low reset
//   btn_raw    in   [3:0] raw button levels, 1 = pressed
//   btn_valid  out  one-cycle press event
//   btn_val    out  [1:0] index of pressed button, held until next event
//   multi_err  out  one-cycle pulse on two or more buttons accepted together
//   btn_db     out  [3:0] debounced levels (debug)
//   state      out  [1:0] press-FSM state (debug)
//
// state  | meaning
// S_ARM  | after reset: wait for all buttons released and settled
// S_IDLE | armed, waiting for a debounced press
// S_HELD | press reported, ignore everything until all buttons released
module simon_btn_cond
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 4
) (
  input  logic               clk_tick,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic               btn_valid,
  output logic [1:0]         btn_val,
  output logic               multi_err,
  output logic [NUM_BTN-1:0] btn_db,
  output logic [1:0]         state
);

  logic [NUM_BTN-1:0] quiet_vec;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    simon_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk_tick(clk_tick),
      .reset_n (reset_n),
      .btn_raw (btn_raw[g]),
      .btn_db  (btn_db[g]),
      .quiet   (quiet_vec[g])
    );
  end

  press_state_e state_q, state_d;
  logic         btn_valid_q, btn_valid_d;
  logic [1:0]   btn_val_q, btn_val_d;
  logic         multi_err_q, multi_err_d;
  logic         arm_ok_q, arm_ok_d;
  logic         settled;
  logic [2:0]   n_set;

  // Right after reset the synchronizers still hold their reset zeros, so
  // btn_db == 0 says nothing about a button that is physically held.
  // Arming therefore needs the inputs released and settled on two
  // consecutive edges; the first edge out of reset only primes arm_ok_q,
  // by which time a held button has already reached sync1.
  assign settled = (&quiet_vec) && (btn_db == '0);
  assign n_set   = count_set(btn_db);

  always_comb begin
    state_d     = state_q;
    btn_valid_d = 1'b0;
    multi_err_d = 1'b0;
    btn_val_d   = btn_val_q;
    arm_ok_d    = settled;
    unique case (state_q)
      S_ARM: begin
        if (settled && arm_ok_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (n_set == 3'd1) begin
          btn_valid_d = 1'b1;
          btn_val_d   = btn_index(btn_db);
          state_d     = S_HELD;
        end else if (n_set > 3'd1) begin
          multi_err_d = 1'b1;
          state_d     = S_HELD;
        end
      end
      S_HELD: begin
        if (btn_db == '0) state_d = S_IDLE;
      end
      default: state_d = S_ARM;
    endcase
  end

  always_ff @(posedge clk_tick) begin
    if (!reset_n) begin
      state_q     <= S_ARM;
      btn_valid_q <= 1'b0;
      btn_val_q   <= BTN_0;
      multi_err_q <= 1'b0;
      arm_ok_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_valid_q <= btn_valid_d;
      btn_val_q   <= btn_val_d;
      multi_err_q <= multi_err_d;
      arm_ok_q    <= arm_ok_d;
    end
  end

  assign btn_valid = btn_valid_q;
  assign btn_val   = btn_val_q;
  assign multi_err = multi_err_q;
  assign state     = state_q;

endmodule
